// File: rtl/apb_req_arbiter.sv
// Two-port round-robin request arbiter in front of a single APB master.
// Out-of-range addresses are answered locally with an error and never reach the bus.
module apb_req_arbiter #(
  parameter int unsigned ADDR_LIMIT = 10,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic        pclk_m,
  input  logic        prstn_m,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        psel_m,
  output logic        penable_m,
  output logic        pwrite_m,
  output logic [31:0] paddr_m,
  output logic [31:0] pwdata_m,
  input  logic [31:0] prdata_m,
  input  logic        pready_m
);

  localparam logic [31:0] LIMIT    = 32'(ADDR_LIMIT);
  localparam logic [3:0]  WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_grant;
  logic        r_port;
  logic [3:0]  r_wait;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_ok0;
  logic        w_ok1;
  logic        w_addr_ok;
  logic        w_psel;
  logic        w_penable;

  assign w_ok0     = (req0_addr <= LIMIT);
  assign w_ok1     = (req1_addr <= LIMIT);
  assign w_addr_ok = w_gnt1 ? w_ok1 : w_ok0;

  // Arbitration, next-state and APB phase decode
  always_comb begin
    w_next    = r_state;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    case (r_state)
      IDLE: begin
        // ready is held low while reset is asserted
        if (prstn_m) begin
          w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
          w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
        end
        if (w_gnt0 || w_gnt1) begin
          w_next = w_addr_ok ? SETUP : RESP;
        end
      end
      SETUP: begin
        w_psel = 1'b1;
        w_next = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (pready_m || (r_wait == WAIT_MAX)) begin
          w_next = RESP;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, request latches, wait counter and response capture
  always_ff @(posedge pclk_m or negedge prstn_m) begin
    if (!prstn_m) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_wait       <= '0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_port       <= w_gnt1;
            r_last_grant <= w_gnt1;
            // Bus-side latches only move for legal addresses so the APB
            // outputs keep their last transfer's values on a local reject.
            if (w_addr_ok) begin
              r_pwrite <= w_gnt1 ? req1_write : req0_write;
              r_paddr  <= w_gnt1 ? req1_addr  : req0_addr;
              r_pwdata <= w_gnt1 ? req1_wdata : req0_wdata;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        SETUP: begin
          r_wait <= '0;
        end
        ACCESS: begin
          if (pready_m) begin
            r_rdata <= r_pwrite ? '0 : prdata_m;
            r_err   <= 1'b0;
          end else if (r_wait == WAIT_MAX) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign psel_m    = w_psel;
  assign penable_m = w_penable;
  assign pwrite_m  = r_pwrite;
  assign paddr_m   = r_paddr;
  assign pwdata_m  = r_pwdata;

  assign rsp0_valid = (r_state == RESP) && !r_port;
  assign rsp1_valid = (r_state == RESP) &&  r_port;
  assign rsp0_rdata = rsp0_valid ? r_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? r_rdata : '0;
  assign rsp0_err   = rsp0_valid && r_err;
  assign rsp1_err   = rsp1_valid && r_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-level reference model, APB slave
// memory with scripted wait states, directed scenarios and random traffic.
module tb_apb_req_arbiter;

  logic        pclk_m = 1'b0;
  logic        prstn_m;
  logic        req0_valid, req0_ready, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        psel_m, penable_m, pwrite_m, pready_m;
  logic [31:0] paddr_m, pwdata_m, prdata_m;

  apb_req_arbiter #(.ADDR_LIMIT(10), .MAX_WAIT(15)) dut (
    .pclk_m(pclk_m), .prstn_m(prstn_m),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .psel_m(psel_m), .penable_m(penable_m), .pwrite_m(pwrite_m),
    .paddr_m(paddr_m), .pwdata_m(pwdata_m), .prdata_m(prdata_m), .pready_m(pready_m)
  );

  always #5 pclk_m = ~pclk_m;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // slave memory (what the bus really holds) and the model's view of it
  logic [31:0] slave_mem [11];
  logic [31:0] ref_mem   [11];

  // transaction-level model state
  logic        m_busy  = 1'b0;
  logic        m_aerr  = 1'b0;
  logic        m_last  = 1'b1;
  logic        m_port  = 1'b0;
  logic        m_write = 1'b0;
  logic        m_err   = 1'b0;
  int          m_k     = 0;   // cycles since acceptance (1 = first cycle after)
  int          m_rk    = 0;   // cycle number carrying the response
  int          m_n     = 0;   // low-pready cycles the slave inserts
  logic [31:0] m_rdata  = '0;
  logic [31:0] m_paddr  = '0;
  logic [31:0] m_pwdata = '0;
  logic        m_pwrite = 1'b0;

  logic dir_mode = 1'b1;
  int   dir_n    = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;
  logic pend0 = 1'b0, pend1 = 1'b0;

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)       return 32'($urandom_range(0, 10));
    else if (r == 8) return 32'($urandom_range(11, 15));
    else             return $urandom;
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12)      return 0;
    else if (r < 17) return $urandom_range(1, 4);
    else if (r < 19) return $urandom_range(5, 15);
    else             return 16 + $urandom_range(0, 3);
  endfunction

  // APB slave write port
  initial forever begin
    @(posedge pclk_m);
    if (prstn_m && psel_m && penable_m && pready_m && pwrite_m && (paddr_m < 32'd11))
      slave_mem[paddr_m[3:0]] = pwdata_m;
  end

  // Slave read data / wait states, and random requesters
  initial forever begin
    @(negedge pclk_m);
    if (m_busy && !m_aerr && (m_k >= 2)) pready_m = ((m_k - 2) >= m_n);
    else                                   pready_m = 1'($urandom_range(0, 1));
    if (paddr_m < 32'd11) prdata_m = slave_mem[paddr_m[3:0]];
    else                  prdata_m = $urandom;
    if (!dir_mode) begin
      if (acc0) begin acc0 = 1'b0; pend0 = 1'b0; end
      if (!pend0 && ($urandom_range(0, 2) == 0)) begin
        pend0 = 1'b1; req0_write = 1'($urandom_range(0, 1));
        req0_addr = rand_addr(); req0_wdata = $urandom;
      end
      req0_valid = pend0;
      if (acc1) begin acc1 = 1'b0; pend1 = 1'b0; end
      if (!pend1 && ($urandom_range(0, 2) == 0)) begin
        pend1 = 1'b1; req1_write = 1'($urandom_range(0, 1));
        req1_addr = rand_addr(); req1_wdata = $urandom;
      end
      req1_valid = pend1;
    end
  end

  // Per-cycle comparison against the transaction model
  initial begin
    logic        e_r0, e_r1, e_psel, e_pen, e_rv, winner;
    logic [31:0] aa, wd;
    int          nn;
    forever begin
      @(negedge pclk_m);
      #1;
      if (!prstn_m) begin
        chkb("rst_req0_ready", req0_ready, 1'b0);
        chkb("rst_req1_ready", req1_ready, 1'b0);
        chkb("rst_psel", psel_m, 1'b0);
        chkb("rst_penable", penable_m, 1'b0);
        chkb("rst_pwrite", pwrite_m, 1'b0);
        chk ("rst_paddr", paddr_m, 32'd0);
        chk ("rst_pwdata", pwdata_m, 32'd0);
        chkb("rst_rsp0_valid", rsp0_valid, 1'b0);
        chkb("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk ("rst_rsp0_rdata", rsp0_rdata, 32'd0);
        chk ("rst_rsp1_rdata", rsp1_rdata, 32'd0);
        chkb("rst_rsp0_err", rsp0_err, 1'b0);
        chkb("rst_rsp1_err", rsp1_err, 1'b0);
        m_busy = 1'b0; m_last = 1'b1; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
      end else begin
        // arbitration: single requester wins; on a tie the one not granted last
        if (req0_valid && req1_valid) winner = !m_last;
        else                          winner = req1_valid;
        e_r0 = !m_busy && (req0_valid || req1_valid) && (winner == 1'b0);
        e_r1 = !m_busy && (req0_valid || req1_valid) && (winner == 1'b1);
        e_psel = m_busy && !m_aerr && (m_k < m_rk);
        e_pen  = e_psel && (m_k >= 2);
        e_rv   = m_busy && (m_k == m_rk);
        chkb("req0_ready", req0_ready, e_r0);
        chkb("req1_ready", req1_ready, e_r1);
        chkb("psel", psel_m, e_psel);
        chkb("penable", penable_m, e_pen);
        chk ("paddr", paddr_m, m_paddr);
        chkb("pwrite", pwrite_m, m_pwrite);
        chk ("pwdata", pwdata_m, m_pwdata);
        chkb("rsp0_valid", rsp0_valid, e_rv && !m_port);
        chkb("rsp1_valid", rsp1_valid, e_rv && m_port);
        if (e_rv) begin
          if (!m_port) begin
            chk ("rsp0_rdata", rsp0_rdata, m_rdata);
            chkb("rsp0_err", rsp0_err, m_err);
            chk ("rsp1_rdata_idle", rsp1_rdata, 32'd0);
            chkb("rsp1_err_idle", rsp1_err, 1'b0);
          end else begin
            chk ("rsp1_rdata", rsp1_rdata, m_rdata);
            chkb("rsp1_err", rsp1_err, m_err);
            chk ("rsp0_rdata_idle", rsp0_rdata, 32'd0);
            chkb("rsp0_err_idle", rsp0_err, 1'b0);
          end
        end
        // advance the model across the coming rising edge
        if (m_busy) begin
          if (m_k == m_rk) m_busy = 1'b0;
          else             m_k++;
        end else if (e_r0 || e_r1) begin
          m_port = e_r1; m_last = e_r1;
          m_write = e_r1 ? req1_write : req0_write;
          aa = e_r1 ? req1_addr  : req0_addr;
          wd = e_r1 ? req1_wdata : req0_wdata;
          nn = dir_mode ? dir_n : pick_wait();
          m_n = nn; m_aerr = (aa > 32'd10); m_busy = 1'b1; m_k = 1;
          if (m_aerr) begin
            m_rk = 1; m_err = 1'b1; m_rdata = '0;
          end else begin
            m_rk  = 3 + ((nn > 15) ? 15 : nn);
            m_err = (nn > 15);
            m_rdata = (m_err || m_write) ? 32'd0 : ref_mem[aa[3:0]];
            m_paddr = aa; m_pwrite = m_write; m_pwdata = wd;
            if (m_write && !m_err) ref_mem[aa[3:0]] = wd;
          end
          if (e_r1) acc1 = 1'b1;
          else      acc0 = 1'b1;
        end
      end
    end
  end

  // One directed transaction: returns cycle offsets (1 = cycle after acceptance)
  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int n, output int psel_at, output int pen_at, output int pen_cnt,
                        output int rsp_at, output logic [31:0] rd, output logic er);
    bit got;
    psel_at = 0; pen_at = 0; pen_cnt = 0; rsp_at = 0; rd = '0; er = 1'b0;
    @(negedge pclk_m);
    dir_n = n;
    if (p == 0) begin req0_write = w; req0_addr = a; req0_wdata = d; req0_valid = 1'b1; end
    else        begin req1_write = w; req1_addr = a; req1_wdata = d; req1_valid = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge pclk_m);
      if (p == 0 && acc0) begin acc0 = 1'b0; got = 1'b1; end
      if (p == 1 && acc1) begin acc1 = 1'b0; got = 1'b1; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!got) begin
      chkb("accept_timeout", 1'b0, 1'b1);
      return;
    end
    for (int idx = 1; idx <= 40; idx++) begin
      #2;
      if (psel_m && psel_at == 0) psel_at = idx;
      if (penable_m) begin pen_cnt++; if (pen_at == 0) pen_at = idx; end
      if ((p == 0) ? rsp0_valid : rsp1_valid) begin
        rsp_at = idx;
        rd = (p == 0) ? rsp0_rdata : rsp1_rdata;
        er = (p == 0) ? rsp0_err : rsp1_err;
        break;
      end
      @(negedge pclk_m);
    end
    if (rsp_at == 0) chkb("rsp_timeout", 1'b0, 1'b1);
  endtask

  // Both ports request continuously; records the grant order
  task automatic run_tie(input int cnt, output logic [3:0] gseq, output int got);
    dir_n = 0; got = 0; gseq = '0;
    @(negedge pclk_m);
    req0_write = 1'b0; req0_addr = 32'd1; req1_write = 1'b0; req1_addr = 32'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 100 && got < cnt; i++) begin
      @(negedge pclk_m);
      if (acc0)      begin acc0 = 1'b0; gseq[got] = 1'b0; got++; end
      else if (acc1) begin acc1 = 1'b0; gseq[got] = 1'b1; got++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    int          ps, pe, pc, ra, got;
    logic [31:0] rd, v;
    logic        er;
    logic [3:0]  gseq;

    prstn_m = 1'b0; pready_m = 1'b0; prdata_m = '0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    for (int i = 0; i < 11; i++) begin
      v = $urandom; slave_mem[i] = v; ref_mem[i] = v;
    end
    repeat (3) @(negedge pclk_m);
    #2;
    chkb("reset_ready0_held_low", req0_ready, 1'b0);
    chkb("reset_psel", psel_m, 1'b0);
    @(negedge pclk_m);
    req0_valid = 1'b0;
    prstn_m = 1'b1;
    repeat (2) @(negedge pclk_m);

    // continuous tie from reset: grants 0,1,0,1
    run_tie(4, gseq, got);
    chk("tie_count", 32'(got), 32'd4);
    chk("tie_order", {28'd0, gseq}, 32'h0000_000A);

    // zero-wait write then read back
    do_txn(0, 1'b1, 32'd3, 32'hDEADBEEF, 0, ps, pe, pc, ra, rd, er);
    chk ("wr_psel_at", 32'(ps), 32'd1);
    chk ("wr_penable_at", 32'(pe), 32'd2);
    chk ("wr_rsp_at", 32'(ra), 32'd3);
    chk ("wr_rdata", rd, 32'd0);
    chkb("wr_err", er, 1'b0);
    do_txn(0, 1'b0, 32'd3, 32'd0, 0, ps, pe, pc, ra, rd, er);
    chk ("rd_rsp_at", 32'(ra), 32'd3);
    chk ("rd_rdata", rd, 32'hDEADBEEF);
    chkb("rd_err", er, 1'b0);

    // address error on port 1
    do_txn(1, 1'b0, 32'd11, 32'd0, 0, ps, pe, pc, ra, rd, er);
    chk ("aerr_psel_at", 32'(ps), 32'd0);
    chk ("aerr_rsp_at", 32'(ra), 32'd1);
    chkb("aerr_err", er, 1'b1);
    chk ("aerr_rdata", rd, 32'd0);

    // three wait states
    do_txn(0, 1'b1, 32'd5, 32'h12345678, 0, ps, pe, pc, ra, rd, er);
    do_txn(0, 1'b0, 32'd5, 32'd0, 3, ps, pe, pc, ra, rd, er);
    chk ("wait3_penable_cycles", 32'(pc), 32'd4);
    chk ("wait3_rsp_at", 32'(ra), 32'd6);
    chk ("wait3_rdata", rd, 32'h12345678);
    chkb("wait3_err", er, 1'b0);

    // timeout, then a normal transfer
    do_txn(0, 1'b0, 32'd5, 32'd0, 20, ps, pe, pc, ra, rd, er);
    chk ("tmo_penable_cycles", 32'(pc), 32'd16);
    chk ("tmo_rsp_at", 32'(ra), 32'd18);
    chkb("tmo_err", er, 1'b1);
    chk ("tmo_rdata", rd, 32'd0);
    do_txn(1, 1'b1, 32'd7, 32'hA5A50001, 0, ps, pe, pc, ra, rd, er);
    chk ("post_tmo_rsp_at", 32'(ra), 32'd3);
    chkb("post_tmo_err", er, 1'b0);
    do_txn(0, 1'b0, 32'd7, 32'd0, 0, ps, pe, pc, ra, rd, er);
    chk ("post_tmo_rdata", rd, 32'hA5A50001);

    // reset during ACCESS
    @(negedge pclk_m);
    dir_n = 20; req0_write = 1'b0; req0_addr = 32'd5; req0_valid = 1'b1;
    @(negedge pclk_m);
    chkb("mid_rst_accept", acc0, 1'b1);
    acc0 = 1'b0; req0_valid = 1'b0;
    repeat (3) @(negedge pclk_m);
    #3;
    chkb("mid_rst_penable_before", penable_m, 1'b1);
    prstn_m = 1'b0;
    #1;
    chkb("mid_rst_psel_async", psel_m, 1'b0);
    chkb("mid_rst_penable_async", penable_m, 1'b0);
    repeat (2) @(negedge pclk_m);
    prstn_m = 1'b1;
    run_tie(2, gseq, got);
    chk("post_rst_tie_count", 32'(got), 32'd2);
    chk("post_rst_tie_order", {28'd0, gseq}, 32'h0000_0002);

    // random traffic
    @(negedge pclk_m);
    dir_mode = 1'b0;
    repeat (3000) @(negedge pclk_m);
    dir_mode = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
    repeat (30) @(negedge pclk_m);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
